// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code pointer receive path.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    FILL  = 2'b00,
    PRIME = 2'b01,
    TRACK = 2'b10
  } gray_rx_state_e;

  // Zero-extended inputs decode correctly in their low bits, so one width serves all users.
  function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic gray_multi_bit(input logic [GRAY_MAX_W-1:0] x);
    return (x & (x - GRAY_MAX_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_2_bin.sv
// Purely combinational Gray-to-binary decoder.
module gray_2_bin
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  assign bin_o = WIDTH'(gray_to_bin(GRAY_MAX_W'(gray_i)));

endmodule

// File: rtl/gray_2_bin_rx.sv
// Synchronises a forward-only Gray pointer into clk_i, decodes it and reports per-sample motion.
module gray_2_bin_rx
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] delta_o,
  output logic             wrap_o,
  output logic             step_err_o
);

  localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] gray_q;
  logic [CNT_W-1:0] fill_cnt;

  gray_rx_state_e   state_q, state_d;
  logic [CNT_W-1:0] fill_cnt_d;
  logic [WIDTH-1:0] bin_d, gray_q_d, delta_d;
  logic             valid_d, wrap_d, err_d;

  // Ungated synchroniser chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign g = sync_q[SYNC_STAGES-1];

  gray_2_bin #(.WIDTH(WIDTH)) u_dec (
    .gray_i (g),
    .bin_o  (b)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= FILL;
      fill_cnt   <= '0;
      bin_o      <= '0;
      gray_q     <= '0;
      delta_o    <= '0;
      valid_o    <= 1'b0;
      wrap_o     <= 1'b0;
      step_err_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt   <= fill_cnt_d;
      bin_o      <= bin_d;
      gray_q     <= gray_q_d;
      delta_o    <= delta_d;
      valid_o    <= valid_d;
      wrap_o     <= wrap_d;
      step_err_o <= err_d;
    end
  end

  // Next-state and next-output logic; pulses default low so they last one cycle.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt;
    bin_d      = bin_o;
    gray_q_d   = gray_q;
    delta_d    = delta_o;
    valid_d    = valid_o;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      FILL: begin
        valid_d = 1'b0;
        delta_d = '0;
        if (fill_cnt == CNT_W'(SYNC_STAGES)) begin
          bin_d    = b;
          gray_q_d = g;
          valid_d  = 1'b1;
          state_d  = PRIME;
        end else begin
          fill_cnt_d = fill_cnt + CNT_W'(1);
        end
      end
      PRIME, TRACK: begin
        bin_d    = b;
        gray_q_d = g;
        delta_d  = WIDTH'(b - bin_o);
        wrap_d   = (b < bin_o);
        err_d    = gray_multi_bit(GRAY_MAX_W'(g ^ gray_q));
        valid_d  = 1'b1;
        state_d  = TRACK;
      end
      default: begin
        state_d    = FILL;
        fill_cnt_d = '0;
        bin_d      = '0;
        gray_q_d   = '0;
        delta_d    = '0;
        valid_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_gray_2_bin_rx.sv
// Randomised and directed bench for gray_2_bin_rx against an input-history reference model.
module tb_gray_2_bin_rx;

  localparam int unsigned W = 4;
  localparam int unsigned S = 2;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] gray_i;
  logic [W-1:0] bin_o;
  logic         valid_o;
  logic [W-1:0] delta_o;
  logic         wrap_o;
  logic         step_err_o;

  int compared   = 0;
  int mismatched = 0;
  int e          = 0;
  logic [3:0] g_hist [0:2047];
  int         n_hist [0:2047];

  gray_2_bin_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .gray_i     (gray_i),
    .bin_o      (bin_o),
    .valid_o    (valid_o),
    .delta_o    (delta_o),
    .wrap_o     (wrap_o),
    .step_err_o (step_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int g2b(input logic [3:0] g);
    for (int v = 0; v < 16; v++) begin
      if (4'(v ^ (v >> 1)) == g) return v;
    end
    return -1;
  endfunction

  function automatic int popc(input logic [3:0] x);
    int c;
    c = 0;
    for (int i = 0; i < 4; i++) c += int'(x[i]);
    return c;
  endfunction

  function automatic logic [3:0] b2g(input int v);
    logic [3:0] t;
    t = 4'(v);
    return t ^ (t >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, e);
    end
  endtask

  // Drive one cycle, record what the edge sampled, return 1 time unit after the edge.
  task automatic step(input logic r, input logic [3:0] g);
    rst_i  = r;
    gray_i = g;
    @(posedge clk_i);
    e++;
    g_hist[e] = g;
    n_hist[e] = r ? 0 : n_hist[e-1] + 1;
    #1;
  endtask

  // Model: after edge e, outputs reflect the inputs sampled S and S+1 edges earlier.
  int n, eb, pb, ed, ew, ee, ev;
  always @(negedge clk_i) begin
    if (e > 0) begin
      n  = n_hist[e];
      ev = 0; eb = 0; ed = 0; ew = 0; ee = 0;
      if (n >= S + 1) begin
        ev = 1;
        eb = g2b(g_hist[e-S]);
      end
      if (n >= S + 2) begin
        pb = g2b(g_hist[e-S-1]);
        ed = (eb - pb + 16) % 16;
        ew = (eb < pb) ? 1 : 0;
        ee = (popc(g_hist[e-S] ^ g_hist[e-S-1]) > 1) ? 1 : 0;
      end
      chk("model_valid", int'(valid_o), ev);
      chk("model_bin", int'(bin_o), eb);
      chk("model_delta", int'(delta_o), ed);
      chk("model_wrap", int'(wrap_o), ew);
      chk("model_step_err", int'(step_err_o), ee);
    end
  end

  int wraps, errs;
  logic [3:0] cur;
  int r;

  initial begin
    n_hist[0] = 0;
    g_hist[0] = '0;

    // Reset and fill
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b1111);
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_bin", int'(bin_o), 0);
      chk("rst_delta", int'(delta_o), 0);
    end
    step(1'b0, 4'b1111);
    chk("fill1_valid", int'(valid_o), 0);
    step(1'b0, 4'b1111);
    chk("fill2_valid", int'(valid_o), 0);
    step(1'b0, 4'b1111);
    chk("fill3_valid", int'(valid_o), 1);
    chk("fill3_bin", int'(bin_o), 10);
    chk("fill3_delta", int'(delta_o), 0);

    // Counting 0..15 then 0
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0000);
    wraps = 0;
    errs  = 0;
    for (int i = 1; i <= 19; i++) begin
      step(1'b0, (i <= 15) ? b2g(i) : 4'b0000);
      wraps += int'(wrap_o);
      errs  += int'(step_err_o);
    end
    chk("count_wraps", wraps, 1);
    chk("count_step_err", errs, 0);

    // Jump 0000 -> 0011
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0011);
    chk("jump_bin", int'(bin_o), 2);
    chk("jump_delta", int'(delta_o), 2);
    chk("jump_step_err", int'(step_err_o), 1);
    chk("jump_wrap", int'(wrap_o), 0);
    step(1'b0, 4'b0011);
    chk("jump_err_clear", int'(step_err_o), 0);

    // Hold 0110
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0110);
    chk("hold_bin", int'(bin_o), 4);
    chk("hold_delta", int'(delta_o), 0);
    chk("hold_wrap", int'(wrap_o), 0);
    chk("hold_step_err", int'(step_err_o), 0);

    // Backward step 5 -> 4
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0111);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0110);
    chk("back_bin", int'(bin_o), 4);
    chk("back_delta", int'(delta_o), 15);
    chk("back_wrap", int'(wrap_o), 1);
    chk("back_step_err", int'(step_err_o), 0);

    // Mid-run reset
    step(1'b1, 4'b0110);
    chk("midrst_valid", int'(valid_o), 0);
    chk("midrst_bin", int'(bin_o), 0);
    step(1'b0, 4'b0110);
    step(1'b0, 4'b0110);
    chk("refill2_valid", int'(valid_o), 0);
    step(1'b0, 4'b0110);
    chk("refill3_valid", int'(valid_o), 1);
    chk("refill3_bin", int'(bin_o), 4);

    // Random mix of increments, holds, jumps, backward steps and resets
    cur = 4'd4;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)      cur = cur + 4'd1;
      else if (r < 75) cur = cur;
      else if (r < 90) cur = 4'($urandom_range(0, 15));
      else if (r < 97) cur = cur - 4'd1;
      step((r >= 97) ? 1'b1 : 1'b0, b2g(int'(cur)));
    end
    step(1'b0, b2g(int'(cur)));
    @(negedge clk_i);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
